sq_arbiter: RTL and testbench
=============================

SQ_ARBITER -- requirements
Module: sq_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning cycles from grant edge to result valid (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req0  input  1  requester 0 request level.
REQ-005 SHALL have port n0  input  4  requester 0 operand.
REQ-006 SHALL have port sign0  input  1  requester 0 format (1 = two's complement, 0 = unsigned).
REQ-007 SHALL have port req1  input  1  requester 1 request level.
REQ-008 SHALL have port n1  input  4  requester 1 operand.
REQ-009 SHALL have port sign1  input  1  requester 1 format.
REQ-010 SHALL have port gnt0  output  1  one-cycle grant pulse to requester 0.
REQ-011 SHALL have port gnt1  output  1  one-cycle grant pulse to requester 1.
REQ-012 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have port out_id  output  1  requester served by current result.
REQ-014 SHALL have port square  output  8  operand squared.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; all outputs except busy registered; busy decoded from state.
REQ-017 IDLE, any req high at edge: SHALL select winner, latch winner's n/sign, assert winner's gnt for exactly the next cycle, load counter with LAT, go CALC.
REQ-018 IDLE, no req: SHALL remain IDLE, gnt0/gnt1 low.
REQ-019 Arbitration SHALL be round-robin via 1-bit pointer ptr: both requesting -> grant requester ptr; exactly one requesting -> grant it; after every grant ptr <= index of the non-granted requester.
REQ-020 CALC: counter==1 at edge -> go DONE, load square and out_id, set out_valid; otherwise decrement counter and stay CALC.
REQ-021 out_valid SHALL therefore rise exactly LAT cycles after the gnt-setting edge (LAT=1: cycle directly after gnt cycle).
REQ-022 DONE SHALL last one cycle, then IDLE with out_valid low; square and out_id SHALL hold until next result.
REQ-023 Requests SHALL be ignored in CALC and DONE; a req still high on return to IDLE SHALL be arbitrated as a new request.
REQ-024 Requester SHALL hold n/sign stable while req high until its gnt; block samples operands only on the grant edge, so later operand changes SHALL not affect the in-flight result.
REQ-025 sign=0: square = n*n, n in 0..15, max 225 (8'hE1).
REQ-026 sign=1: n as signed -8..7, square = n*n, max 64 (n=4'b1000); no overflow possible in 8 bits.
REQ-027 Squaring SHALL be a 16-entry-per-format combinational lookup on the latched operand; no multiplier needed.
REQ-028 At most one of gnt0, gnt1 SHALL be high in any cycle; at most one grant SHALL be outstanding.
REQ-029 Throughput: one result per LAT+2 cycles under continuous requests.

Reset
REQ-030 rst high at edge SHALL force state IDLE, ptr 0, counter 0, gnt0 0, gnt1 0, out_valid 0, out_id 0, square 8'h00; busy 0 from next cycle.
REQ-031 rst SHALL override all other conditions, including mid-CALC and DONE; aborted operation SHALL produce no out_valid.
REQ-032 First grant after reset with both req high SHALL go to requester 0.

Verification
REQ-033 Reset, no req for 10 cycles -> gnt0/gnt1/out_valid/busy remain 0, square 8'h00.
REQ-034 LAT=2, req0=1, n0=4'b1111, sign0=0 -> gnt0 one cycle, out_valid 2 cycles later, square=225, out_id=0.
REQ-035 req1 n1=4'b1111 sign1=1 -> square=1, out_id=1; n1=4'b1000 sign1=1 -> square=64.
REQ-036 Both req held high from reset -> grant order 0,1,0,1; grants spaced LAT+2 cycles; each square correct for its requester.
REQ-037 rst asserted one cycle after gnt0 -> next cycle IDLE, busy 0, out_valid never rises, next dual request grants requester 0.
REQ-038 Sweep all 16 n x 2 sign via req0, LAT=1 and LAT=15 -> every square matches golden n*n, latency equals LAT.

Source files
------------

// File: rtl/sq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sq_arbiter
//  Purpose  : Two-requester round-robin arbiter in front of a 4-bit squarer
//             (unsigned or two's-complement operand) with a fixed, parameter-
//             selected latency from grant to result strobe.
//  Revision : 1.0  initial release
// ============================================================================
module sq_arbiter #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] n0,
  input  logic       sign0,
  input  logic       req1,
  input  logic [3:0] n1,
  input  logic       sign1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       out_valid,
  output logic       out_id,
  output logic [7:0] square,
  output logic       busy
);

  localparam logic [3:0] C_LAT = 4'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [3:0] op_q, op_d;
  logic       sgn_q, sgn_d;
  logic       id_q, id_d;
  logic       out_valid_q, out_valid_d;
  logic       out_id_q, out_id_d;
  logic [7:0] square_q, square_d;

  logic       w_win;
  logic [3:0] w_mag;
  logic [7:0] w_sq;

  // Square lookup on the latched operand: a negative signed operand is folded
  // to its magnitude (-8 folds to 8), then indexes the 16-entry table.
  always_comb begin
    w_mag = (sgn_q && op_q[3]) ? (4'd0 - op_q) : op_q;
    case (w_mag)
      4'd0:    w_sq = 8'd0;
      4'd1:    w_sq = 8'd1;
      4'd2:    w_sq = 8'd4;
      4'd3:    w_sq = 8'd9;
      4'd4:    w_sq = 8'd16;
      4'd5:    w_sq = 8'd25;
      4'd6:    w_sq = 8'd36;
      4'd7:    w_sq = 8'd49;
      4'd8:    w_sq = 8'd64;
      4'd9:    w_sq = 8'd81;
      4'd10:   w_sq = 8'd100;
      4'd11:   w_sq = 8'd121;
      4'd12:   w_sq = 8'd144;
      4'd13:   w_sq = 8'd169;
      4'd14:   w_sq = 8'd196;
      default: w_sq = 8'd225;
    endcase
  end

  // Next-state logic: arbitration in IDLE, latency countdown in CALC,
  // single-cycle DONE. Grant and strobe outputs default low each cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    op_d        = op_q;
    sgn_d       = sgn_q;
    id_d        = id_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    square_d    = square_q;
    // Both requesting: pointer decides; otherwise the lone requester wins.
    w_win       = (req0 && req1) ? ptr_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0_d  = ~w_win;
          gnt1_d  = w_win;
          op_d    = w_win ? n1 : n0;
          sgn_d   = w_win ? sign1 : sign0;
          id_d    = w_win;
          ptr_d   = ~w_win;
          cnt_d   = C_LAT;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == 4'd1) begin
          square_d    = w_sq;
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      op_q        <= 4'd0;
      sgn_q       <= 1'b0;
      id_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      square_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      square_q    <= square_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign square    = square_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sq_arbiter
//  Purpose  : Directed self-checking bench for sq_arbiter. Instance 0 uses
//             LAT=2, instance 1 LAT=1, instance 2 LAT=15.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sq_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_a [3];
  logic [3:0] n0_a [3];
  logic       sign0_a [3];
  logic       req1_a [3];
  logic [3:0] n1_a [3];
  logic       sign1_a [3];
  logic       gnt0_a [3];
  logic       gnt1_a [3];
  logic       out_valid_a [3];
  logic       out_id_a [3];
  logic [7:0] square_a [3];
  logic       busy_a [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sq_arbiter #(.LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .req0(req0_a[0]), .n0(n0_a[0]), .sign0(sign0_a[0]),
    .req1(req1_a[0]), .n1(n1_a[0]), .sign1(sign1_a[0]),
    .gnt0(gnt0_a[0]), .gnt1(gnt1_a[0]), .out_valid(out_valid_a[0]),
    .out_id(out_id_a[0]), .square(square_a[0]), .busy(busy_a[0])
  );

  sq_arbiter #(.LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0(req0_a[1]), .n0(n0_a[1]), .sign0(sign0_a[1]),
    .req1(req1_a[1]), .n1(n1_a[1]), .sign1(sign1_a[1]),
    .gnt0(gnt0_a[1]), .gnt1(gnt1_a[1]), .out_valid(out_valid_a[1]),
    .out_id(out_id_a[1]), .square(square_a[1]), .busy(busy_a[1])
  );

  sq_arbiter #(.LAT(15)) u_lat15 (
    .clk(clk), .rst(rst),
    .req0(req0_a[2]), .n0(n0_a[2]), .sign0(sign0_a[2]),
    .req1(req1_a[2]), .n1(n1_a[2]), .sign1(sign1_a[2]),
    .gnt0(gnt0_a[2]), .gnt1(gnt1_a[2]), .out_valid(out_valid_a[2]),
    .out_id(out_id_a[2]), .square(square_a[2]), .busy(busy_a[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] golden(input logic [3:0] n, input logic s);
    int v;
    v = (s && n[3]) ? int'(n) - 16 : int'(n);
    return 8'(v * v);
  endfunction

  task automatic do_reset();
    for (int w = 0; w < 3; w++) begin
      req0_a[w] = 1'b0; n0_a[w] = 4'd0; sign0_a[w] = 1'b0;
      req1_a[w] = 1'b0; n1_a[w] = 4'd0; sign1_a[w] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction on instance w from requester id.
  task automatic serve(input int w, input int id, input logic [3:0] n,
                       input logic s, input int lat, input string tag);
    logic [7:0] exp_sq;
    logic seen, ov, g;
    int k;
    exp_sq = golden(n, s);
    if (id == 0) begin req0_a[w] = 1'b1; n0_a[w] = n; sign0_a[w] = s; end
    else         begin req1_a[w] = 1'b1; n1_a[w] = n; sign1_a[w] = s; end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      g = (id == 0) ? gnt0_a[w] : gnt1_a[w];
      if (g === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s grant_timeout inst%0d n=%0d s=%0d got none req grant", tag, w, n, s);
      req0_a[w] = 1'b0; req1_a[w] = 1'b0;
      return;
    end
    checks++;
    if (((id == 0) ? gnt1_a[w] : gnt0_a[w]) !== 1'b0) begin
      errors++;
      $display("FAIL %s other_gnt inst%0d got 1 req 0", tag, w);
    end
    // Withdraw and scramble operand: the in-flight result must not change.
    if (id == 0) begin req0_a[w] = 1'b0; n0_a[w] = ~n; sign0_a[w] = ~s; end
    else         begin req1_a[w] = 1'b0; n1_a[w] = ~n; sign1_a[w] = ~s; end
    k = 0;
    ov = 1'b0;
    while (!ov && k < 40) begin
      tick();
      k++;
      if (k == 1) begin
        checks++;
        if (gnt0_a[w] !== 1'b0 || gnt1_a[w] !== 1'b0) begin
          errors++;
          $display("FAIL %s gnt_pulse inst%0d got %b%b req 00", tag, w, gnt0_a[w], gnt1_a[w]);
        end
      end
      if (out_valid_a[w] === 1'b1) ov = 1'b1;
    end
    checks++;
    if (!ov || k != lat) begin
      errors++;
      $display("FAIL %s latency inst%0d n=%0d s=%0d got %0d req %0d", tag, w, n, s, k, lat);
    end
    checks++;
    if (square_a[w] !== exp_sq) begin
      errors++;
      $display("FAIL %s square inst%0d n=%0d s=%0d got %0d req %0d", tag, w, n, s, square_a[w], exp_sq);
    end
    checks++;
    if (out_id_a[w] !== 1'(id)) begin
      errors++;
      $display("FAIL %s out_id inst%0d got %0d req %0d", tag, w, out_id_a[w], id);
    end
    tick();
    checks++;
    if (out_valid_a[w] !== 1'b0 || busy_a[w] !== 1'b0 || square_a[w] !== exp_sq) begin
      errors++;
      $display("FAIL %s done_idle inst%0d got ov=%b busy=%b sq=%0d req ov=0 busy=0 sq=%0d",
               tag, w, out_valid_a[w], busy_a[w], square_a[w], exp_sq);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (gnt0_a[0] !== 1'b0 || gnt1_a[0] !== 1'b0 || out_valid_a[0] !== 1'b0 ||
          busy_a[0] !== 1'b0 || square_a[0] !== 8'h00 || out_id_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got g0=%b g1=%b ov=%b busy=%b sq=%h id=%b req all 0",
                 c, gnt0_a[0], gnt1_a[0], out_valid_a[0], busy_a[0], square_a[0], out_id_a[0]);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    serve(0, 0, 4'b1111, 1'b0, 2, "u15");
    serve(0, 1, 4'b1111, 1'b1, 2, "sm1");
    serve(0, 1, 4'b1000, 1'b1, 2, "sm8");
    serve(0, 0, 4'b1001, 1'b1, 2, "sm7");
  endtask

  task automatic test_round_robin();
    int gid [4];
    int gcyc [4];
    int ng, cyc;
    logic [7:0] exp_sq;
    for (int w = 0; w < 3; w++) begin req0_a[w] = 1'b0; req1_a[w] = 1'b0; end
    req0_a[0] = 1'b1; n0_a[0] = 4'd3;    sign0_a[0] = 1'b0;  // 9
    req1_a[0] = 1'b1; n1_a[0] = 4'b1110; sign1_a[0] = 1'b1;  // -2 -> 4
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ng = 0;
    cyc = 0;
    while (ng < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (gnt0_a[0] === 1'b1 && gnt1_a[0] === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL rr_dual_gnt cyc%0d got 11 req at most one", cyc);
      end
      if (gnt0_a[0] === 1'b1 || gnt1_a[0] === 1'b1) begin
        gid[ng] = gnt1_a[0] ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      if (out_valid_a[0] === 1'b1) begin
        exp_sq = out_id_a[0] ? 8'd4 : 8'd9;
        checks++;
        if (square_a[0] !== exp_sq) begin
          errors++;
          $display("FAIL rr_square id%0d got %0d req %0d", out_id_a[0], square_a[0], exp_sq);
        end
      end
    end
    checks++;
    if (ng != 4) begin
      errors++;
      $display("FAIL rr_grant_count got %0d req 4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gid[i] != (i % 2)) begin
          errors++;
          $display("FAIL rr_order grant%0d got %0d req %0d", i, gid[i], i % 2);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 4) begin
            errors++;
            $display("FAIL rr_spacing grant%0d got %0d req 4", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    req0_a[0] = 1'b0;
    req1_a[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_abort();
    logic seen;
    do_reset();
    req0_a[0] = 1'b1; n0_a[0] = 4'd5; sign0_a[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (gnt0_a[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_gnt got none req gnt0");
    end
    req0_a[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_a[0] !== 1'b0 || gnt0_a[0] !== 1'b0 || out_valid_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b g0=%b ov=%b req 000", busy_a[0], gnt0_a[0], out_valid_a[0]);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_result cyc%0d got 1 req 0", i);
      end
    end
    req0_a[0] = 1'b1; n0_a[0] = 4'd2; sign0_a[0] = 1'b0;
    req1_a[0] = 1'b1; n1_a[0] = 4'd3; sign1_a[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (gnt0_a[0] === 1'b1 || gnt1_a[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || gnt0_a[0] !== 1'b1 || gnt1_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_first_grant got g0=%b g1=%b req g0=1 g1=0", gnt0_a[0], gnt1_a[0]);
    end
    req0_a[0] = 1'b0;
    req1_a[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_sweep();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 16; n++) begin
        serve(1, 0, 4'(n), 1'(s), 1, "sweep_lat1");
        serve(2, 0, 4'(n), 1'(s), 15, "sweep_lat15");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got running req finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
